quad_step_decoder: RTL

//  Quadrature (A/B phase) input decoder. Converts two asynchronous phase signals into
//  up/down step commands plus a wrapping position count, with the same load/enable/direction

---
 rtl/quad_step_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature (A/B phase) decoder with wrapping position count.
// Each asynchronous phase input passes through SYNC_STAGES flops before decoding.
// Gray-code transitions produce one-cycle step pulses with a held direction.
// Transitions where both phases change produce one-cycle err pulses.
// The L/D parallel load has priority over stepping for O only.
// Optional feature macro: GLITCH_FILTER_EN. When defined, each synchronized phase
// passes a two-cycle stability filter, which adds one edge of latency.
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qa,
  input  logic             qb,
  input  logic [WIDTH-1:0] D,
  input  logic             L,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [WIDTH-1:0] O
);

  typedef enum logic [0:0] {S_INIT, S_TRACK} state_e;

`ifdef GLITCH_FILTER_EN
  localparam int PRIME_CYCLES = SYNC_STAGES + 2;
`else
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int CNT_W = $clog2(PRIME_CYCLES + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             cur;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       prime_q, prime_d;
  logic [1:0]             prev_q, prev_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   dir_q, dir_d;
  logic [WIDTH-1:0]       o_q, o_d;

  // Shift each phase through its synchronizer chain (bit 0 is the pin-side stage).
  // NOTE: synchronizer flops are reset so that decoding never sees X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], qa};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], qb};
    end
  end

`ifdef GLITCH_FILTER_EN
  logic a_filt_q, b_filt_q;

  // Accept a new level only when the last two synchronizer stages agree.
  // The two stages hold consecutive samples, so a one-cycle pulse is never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_filt_q <= 1'b0;
      b_filt_q <= 1'b0;
    end else begin
      if (a_sync_q[SYNC_STAGES-1] == a_sync_q[SYNC_STAGES-2]) a_filt_q <= a_sync_q[SYNC_STAGES-1];
      if (b_sync_q[SYNC_STAGES-1] == b_sync_q[SYNC_STAGES-2]) b_filt_q <= b_sync_q[SYNC_STAGES-1];
    end
  end

  assign cur = {a_filt_q, b_filt_q};
`else
  assign cur = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
`endif

  // Decoder state, previous phase pair, and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  //       samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      prime_q <= '0;
      prev_q  <= 2'b00;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      o_q     <= o_d;
    end
  end

  // Next state: prime prev until the input pipeline holds post-reset pin levels,
  // then classify each {prev, cur} pair as up, down, illegal, or idle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d = state_q;
    prime_d = prime_q;
    prev_d  = cur;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    o_d     = o_q;

    unique case (state_q)
      // The synchronizers reset to 0, so pin levels present at release take a few
      // edges to arrive. Staying here until they do keeps those levels from
      // looking like a transition.
      S_INIT: begin
        prime_d = prime_q + CNT_W'(1);
        if (prime_q == CNT_W'(PRIME_CYCLES - 1)) state_d = S_TRACK;
      end
      S_TRACK: begin
        unique case ({prev_q, cur})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            o_d    = o_q + WIDTH'(1);
          end
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            o_d    = o_q - WIDTH'(1);
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = S_INIT;
    endcase

    // A load overrides only the count; step, dir and err still report the transition.
    if (L) o_d = D;
  end

  assign step = step_q;
  assign err  = err_q;
  assign dir  = dir_q;
  assign O    = o_q;

endmodule
